// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  // Operation encodings, equal to funct[1:0] of the MULT/DIV family.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift for multiply, restoring subtract-shift for divide.
// Multiply: {acc_hi,acc_lo} is {partial product, remaining multiplier bits}, shifted right.
// Divide:   {acc_hi,acc_lo} is {partial remainder, dividend/quotient bits}, shifted left.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              div_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [DATA_W-1:0] acc_hi_i,
  input  logic [DATA_W-1:0] acc_lo_i,
  output logic [DATA_W-1:0] acc_hi_o,
  output logic [DATA_W-1:0] acc_lo_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Compute both candidate iterations and select by operation class.
  always_comb begin
    sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted  = {acc_hi_i, acc_lo_i[DATA_W-1]};
    diff     = shifted - {1'b0, opnd_i};
    acc_hi_o = sum[DATA_W:1];
    acc_lo_o = {sum[0], acc_lo_i[DATA_W-1:1]};
    if (div_i) begin
      // diff[DATA_W] is the borrow: set means the divisor did not fit, so restore.
      if (!diff[DATA_W]) begin
        acc_hi_o = diff[DATA_W-1:0];
        acc_lo_o = {acc_lo_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_hi_o = shifted[DATA_W-1:0];
        acc_lo_o = {acc_lo_i[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting; MTHI/MTLO writes accepted, start launches an operation
// CALC  | one radix-2 iteration per edge on unsigned magnitudes
// FIX   | sign correction / divide-by-zero result, HI/LO written
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] orig_a_q, orig_a_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [2*DATA_W-1:0] prod_mag, prod_fix;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .div_i    (div_q),
    .opnd_i   (opnd_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // Operand magnitudes for the signed ops; the most negative value maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & src_a[DATA_W-1];
    b_neg     = signed_op & src_b[DATA_W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    prod_mag  = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_q ? -prod_mag : prod_mag;
  end

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    dz_d      = dz_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    orig_a_d  = orig_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Start wins over any MTHI/MTLO write in the same cycle.
          state_d   = CALC;
          cnt_d     = '0;
          div_d     = op[1];
          dz_d      = op[1] && (src_b == '0);
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          orig_a_d  = src_a;
          acc_hi_d  = '0;
          if (op[1]) begin
            opnd_d   = b_mag;
            acc_lo_d = a_mag;
          end else begin
            opnd_d   = a_mag;
            acc_lo_d = b_mag;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          if (dz_q) begin
            hi_d = orig_a_q;
            lo_d = '1;
          end else begin
            lo_d = neg_q ? -acc_lo_q : acc_lo_q;
            hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
          end
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath, HI/LO and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      orig_a_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      dz_q      <= dz_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      orig_a_q  <= orig_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and completion cycle, a monitor checks on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata, hi, lo;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm,
                        input bit wr);
    exp_t e;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    hi_we = wr; lo_we = wr; wdata = 32'hDEADBEEF;
    e.hi = ehi; e.lo = elo; e.cyc = cyc + 34; e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({nm, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    launch(o, a, b, ehi, elo, nm, 1'b0);
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin");
    do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    do_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7");
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minbym1");
    do_op(OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0");
    do_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7bym2");

    // MTLO alone, then MTHI+MTLO together
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hCAFEF00D);
    check("mtlo_hi_kept", hi, 32'h00000001);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA55AA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo_hi", hi, 32'h55AA55AA);
    check("mthilo_lo", lo, 32'h55AA55AA);

    // start together with MTHI/MTLO: writes dropped
    launch(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_startwr", 1'b1);
    check("startwr_hi_kept", hi, 32'h55AA55AA);
    check("startwr_lo_kept", lo, 32'h55AA55AA);
    wait_idle("multu_startwr");

    // start and MTHI while busy: ignored, hi/lo hold through CALC
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_busyign", 1'b0);
    repeat (4) @(negedge clk);
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h11111111;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; src_a = 32'h0BADF00D; src_b = 32'h0;
    check("busyign_hi_held", hi, 32'd0);
    check("busyign_lo_held", lo, 32'd12);
    check("busyign_busy", {31'b0, busy}, 32'd1);
    wait_idle("mult_busyign");

    // reset mid-DIV aborts without done
    @(negedge clk);
    op = OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    do_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");

    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
